// File: rtl/cfg_lut_k.sv
// K-input look-up table element with a serially loaded truth table. The table
// is shifted MSB-first into a shadow, committed atomically, and read through an
// optional output register.
module cfg_lut_k #(
  parameter int                 K    = 4,
  parameter logic [(1<<K)-1:0]  INIT = 16'h6996
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [K-1:0]  I,
  input  logic          reg_mode,
  input  logic          ce,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic          cfg_bit,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          Q,
  output logic          O
);

  localparam int             N        = 1 << K;
  localparam logic [K:0]     CNT_LAST = (K+1)'(N - 1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    table_q, table_nxt;
  // The shadow's top bit would only ever be shifted out or go straight into the
  // commit word, so the shadow stores N-1 bits and the commit uses 'shifted'.
  logic [N-2:0]    shadow_q, shadow_nxt;
  logic [N-1:0]    shifted;
  logic [K:0]      cnt_q, cnt_nxt;
  logic            done_nxt;
  logic            lut_val;

  assign lut_val  = table_q[I];
  assign shifted  = {shadow_q, cfg_bit};
  assign O        = reg_mode ? Q : lut_val;
  assign cfg_busy = (state == LOAD);

  // NOTE: every output of this block is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    table_nxt  = table_q;
    shadow_nxt = shadow_q;
    cnt_nxt    = cnt_q;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (cfg_start) begin
          // Restart wins over a coincident valid bit; stale shadow bits are
          // simply overwritten by the fresh load.
          cnt_nxt = '0;
        end else if (cfg_valid) begin
          shadow_nxt = shifted[N-2:0];
          cnt_nxt    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            table_nxt = shifted;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            cnt_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values present before the edge (Q sees the old table at commit).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the table is real configuration state and must come out of reset
      // as INIT, so it is reset explicitly rather than left uninitialised.
      state    <= IDLE;
      table_q  <= INIT;
      shadow_q <= '0;
      cnt_q    <= '0;
      cfg_done <= 1'b0;
      Q        <= 1'b0;
    end else begin
      state    <= state_nxt;
      table_q  <= table_nxt;
      shadow_q <= shadow_nxt;
      cnt_q    <= cnt_nxt;
      cfg_done <= done_nxt;
      if (ce) Q <= lut_val;
    end
  end

endmodule

// File: tb/tb_cfg_lut_k.sv
// Directed bench for cfg_lut_k: a default K=4 parity element and a K=2 XOR2
// element share the clock and reset.
module tb_cfg_lut_k;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] i4;
  logic       reg_mode, ce, cfg_start, cfg_valid, cfg_bit;
  logic       busy, done, q, o;

  logic [1:0] i2;
  logic       reg_mode2, ce2, cfg_start2, cfg_valid2, cfg_bit2;
  logic       busy2, done2, q2, o2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cfg_lut_k dut4 (
    .clk(clk), .rst_n(rst_n), .I(i4), .reg_mode(reg_mode), .ce(ce),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_busy(busy), .cfg_done(done), .Q(q), .O(o)
  );

  cfg_lut_k #(.K(2), .INIT(4'h6)) dut2 (
    .clk(clk), .rst_n(rst_n), .I(i2), .reg_mode(reg_mode2), .ce(ce2),
    .cfg_start(cfg_start2), .cfg_valid(cfg_valid2), .cfg_bit(cfg_bit2),
    .cfg_busy(busy2), .cfg_done(done2), .Q(q2), .O(o2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start4();
    cfg_start = 1'b1;
    cfg_valid = 1'b0;
    tick();
    cfg_start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  // Shift n bits of w MSB-first, with optional idle gaps before each bit.
  // done must stay low except after the 16th bit, which the caller checks.
  task automatic bits4(input logic [15:0] w, input int n, input int gap_mod,
                       input bit chk_o, input logic exp_o);
    int gap;
    for (int j = 0; j < n; j++) begin
      gap = (gap_mod > 0) ? ((j * 5 + 3) % gap_mod) : 0;
      for (int g = 0; g < gap; g++) begin
        cfg_valid = 1'b0;
        tick();
        check("gap_done_low", done, 1'b0);
        check("gap_busy_high", busy, 1'b1);
        if (chk_o) check("gap_o_old_table", o, exp_o);
      end
      cfg_valid = 1'b1;
      cfg_bit   = w[15-j];
      tick();
      cfg_valid = 1'b0;
      if (!(n == 16 && j == 15)) begin
        check("bit_done_low", done, 1'b0);
        check("bit_busy_high", busy, 1'b1);
        if (chk_o) check("bit_o_old_table", o, exp_o);
      end
    end
  endtask

  initial begin
    logic       prev;
    logic       exp_q;
    logic [3:0] w2;

    rst_n = 1'b0;
    i4 = '0; reg_mode = 1'b0; ce = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    i2 = '0; reg_mode2 = 1'b0; ce2 = 1'b1; cfg_start2 = 1'b0; cfg_valid2 = 1'b0; cfg_bit2 = 1'b0;
    tick();
    tick();
    check("rst_q", q, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    rst_n = 1'b1;

    // Reset table is 4-input odd parity; O is combinational with reg_mode=0.
    for (int i = 0; i < 16; i++) begin
      i4 = 4'(i);
      #1;
      check("parity_sweep", o, ^i4);
    end
    i4 = 4'b0111; #1; check("parity_0111", o, 1'b1);
    i4 = 4'b0011; #1; check("parity_0011", o, 1'b0);

    // AND4 with back-to-back bits: done lands 16 edges after the start edge.
    start4();
    bits4(16'h8000, 16, 0, 1'b0, 1'b0);
    check("and4_done", done, 1'b1);
    check("and4_busy_fall", busy, 1'b0);
    tick();
    check("and4_done_single", done, 1'b0);
    i4 = 4'hF; #1; check("and4_F", o, 1'b1);
    i4 = 4'hE; #1; check("and4_E", o, 1'b0);
    i4 = 4'h7; #1; check("and4_7_no_parity", o, 1'b0);

    // OR4 with idle gaps, I held at 1: AND4 gives 0 until the done cycle.
    i4 = 4'h1; #1;
    check("or4_pre_o", o, 1'b0);
    start4();
    check("or4_start_o", o, 1'b0);
    bits4(16'hFFFE, 16, 4, 1'b1, 1'b0);
    check("or4_done", done, 1'b1);
    check("or4_o_in_done_cycle", o, 1'b1);
    check("q_old_table_at_commit", q, 1'b0);
    tick();
    check("q_new_table_after", q, 1'b1);
    check("or4_done_single", done, 1'b0);
    i4 = 4'h0; #1; check("or4_0", o, 1'b0);
    i4 = 4'h8; #1; check("or4_8", o, 1'b1);

    // Restart after 9 bits; the bit coinciding with cfg_start is dropped.
    start4();
    bits4(16'hFFFF, 9, 0, 1'b0, 1'b0);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check("restart_done_low", done, 1'b0);
    check("restart_busy", busy, 1'b1);
    bits4(16'h0001, 16, 0, 1'b0, 1'b0);
    check("restart_done", done, 1'b1);
    tick();
    check("restart_done_single", done, 1'b0);
    i4 = 4'h0; #1; check("t0001_0", o, 1'b1);
    i4 = 4'h1; #1; check("t0001_1", o, 1'b0);
    i4 = 4'hF; #1; check("t0001_F", o, 1'b0);

    // Reset mid-load aborts and restores INIT, not the last committed table.
    start4();
    bits4(16'h0000, 5, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_q", q, 1'b0);
    rst_n = 1'b1;
    i4 = 4'h7; #1; check("midrst_parity_7", o, 1'b1);
    i4 = 4'h3; #1; check("midrst_parity_3", o, 1'b0);
    i4 = 4'h0; #1; check("midrst_parity_0", o, 1'b0);

    // Registered path: O shows the parity of I from the previous edge.
    reg_mode = 1'b1;
    ce = 1'b1;
    i4 = 4'h1;
    tick();
    for (int k = 0; k < 6; k++) begin
      prev = ^i4;
      i4 = (i4 == 4'h1) ? 4'h3 : 4'h1;
      #1;
      check("regmode_delayed", o, prev);
      tick();
    end
    exp_q = ^i4;
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i4 = (i4 == 4'h1) ? 4'h3 : 4'h1;
      tick();
      check("ce0_o_frozen", o, exp_q);
      check("ce0_q_frozen", q, exp_q);
    end
    reg_mode = 1'b0;
    ce = 1'b1;

    // K=2 element: XOR2 after reset, then AND2 after a 4-bit load.
    for (int i = 0; i < 4; i++) begin
      i2 = 2'(i);
      #1;
      check("k2_xor2", o2, ^i2);
    end
    w2 = 4'h8;
    cfg_start2 = 1'b1;
    tick();
    cfg_start2 = 1'b0;
    check("k2_busy", busy2, 1'b1);
    for (int j = 0; j < 4; j++) begin
      cfg_valid2 = 1'b1;
      cfg_bit2   = w2[3-j];
      tick();
      if (j < 3) check("k2_done_low", done2, 1'b0);
    end
    cfg_valid2 = 1'b0;
    check("k2_done", done2, 1'b1);
    tick();
    check("k2_done_single", done2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      i2 = 2'(i);
      #1;
      check("k2_and2", o2, &i2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
